bus_ictl: RTL and testbench

//   Parametrised bus interconnect for the ECO32 single-master bus. Decodes
//   the 30-bit word address onto NSLV slave strobes from per-slave base/mask

---
 rtl/bus_ictl_pkg.sv | 14 +
 rtl/bus_ictl_dec.sv | 34 +++
 rtl/bus_ictl.sv | 149 ++++++++++++++
 tb/tb_bus_ictl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ictl_pkg.sv
// Shared definitions for the ECO32 bus interconnect.
// This file holds the bus widths and the FSM state encodings.
package bus_ictl_pkg;

  localparam int BUS_AW = 30;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_ictl_dec.sv
// Combinational address decoder.
// Compares the address against each slave's base/mask pair and keeps only the lowest-index hit.
module bus_dec
  import bus_ictl_pkg::*;
#(
  parameter int                       NSLV     = 16,
  parameter logic [NSLV*BUS_AW-1:0]   SLV_BASE = '0,
  parameter logic [NSLV*BUS_AW-1:0]   SLV_MASK = '0
) (
  input  logic [BUS_AW-1:0] addr,
  output logic [NSLV-1:0]   sel,
  output logic              hit
);

  logic [NSLV-1:0] match;
  // taken[i] is set when any slave below index i already matched
  logic [NSLV:0]   taken;

  assign taken[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
      localparam logic [BUS_AW-1:0] BASE = SLV_BASE[BUS_AW*gi +: BUS_AW];
      localparam logic [BUS_AW-1:0] MASK = SLV_MASK[BUS_AW*gi +: BUS_AW];

      assign match[gi]   = ((addr ^ BASE) & MASK) == '0;
      assign sel[gi]     = match[gi] & ~taken[gi];
      assign taken[gi+1] = taken[gi] | match[gi];
    end
  endgenerate

  assign hit = taken[NSLV];

endmodule

// File: rtl/bus_ictl.sv
// Single-master bus interconnect.
// It decodes slave strobes, muxes read data and ack, terminates unmapped or timed-out cycles, and captures bus errors.
module bus_ictl
  import bus_ictl_pkg::*;
#(
  parameter int                       NSLV     = 16,
  parameter logic [NSLV*BUS_AW-1:0]   SLV_BASE = '0,
  parameter logic [NSLV*BUS_AW-1:0]   SLV_MASK = '0,
  parameter int                       TIMEOUT  = 255,
  parameter int                       TW       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_stb,
  input  logic                     bus_we,
  input  logic [BUS_AW-1:0]        bus_addr,
  output logic [BUS_DW-1:0]        bus_din,
  output logic                     bus_ack,
  output logic [NSLV-1:0]          slv_stb,
  input  logic [NSLV*BUS_DW-1:0]   slv_dout,
  input  logic [NSLV-1:0]          slv_ack,
  output logic                     berr_irq,
  output logic [BUS_AW-1:0]        berr_addr,
  output logic                     berr_we,
  output logic                     berr_ovf,
  input  logic                     berr_clr
);

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX  = '1;

  bus_state_e         state_reg, state_next;
  logic [TW-1:0]      cnt_reg, cnt_next;
  logic               enter_term;

  logic               berr_irq_reg;
  logic [BUS_AW-1:0]  berr_addr_reg;
  logic               berr_we_reg;
  logic               berr_ovf_reg;

  logic [NSLV-1:0]    sel;
  logic               hit;
  logic [BUS_DW-1:0]  sel_din;
  logic               sel_ack;
  logic               term;

  bus_dec #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (bus_addr),
    .sel  (sel),
    .hit  (hit)
  );

  // sel is one-hot or zero, so an AND-OR mux is sufficient
  always_comb begin
    sel_din = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel[i]) begin
        sel_din = sel_din | slv_dout[BUS_DW*i +: BUS_DW];
      end
    end
  end

  assign sel_ack = |(sel & slv_ack);
  assign term    = (state_reg == ST_TERM);

  // Gating with rst_n makes a reset mid-cycle withdraw the strobes and ack at once
  assign slv_stb = (rst_n && bus_stb && !term) ? sel : '0;
  assign bus_ack = rst_n && (term || (bus_stb && sel_ack));
  assign bus_din = term ? '0 : sel_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_term = 1'b0;
    case (state_reg)
      ST_IDLE, ST_WAIT: begin
        if (!bus_stb) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (!hit) begin
          state_next = ST_TERM;
          cnt_next   = '0;
          enter_term = 1'b1;
        end else if (sel_ack) begin
          // An ack arriving on the last counted cycle still completes normally
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_TERM;
          cnt_next   = '0;
          enter_term = 1'b1;
        end else begin
          state_next = ST_WAIT;
          cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end
      end
      ST_TERM: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A new error beats a simultaneous clear, giving a fresh capture with ovf cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      berr_irq_reg  <= 1'b0;
      berr_addr_reg <= '0;
      berr_we_reg   <= 1'b0;
      berr_ovf_reg  <= 1'b0;
    end else if (enter_term) begin
      if (!berr_irq_reg || berr_clr) begin
        berr_irq_reg  <= 1'b1;
        berr_addr_reg <= bus_addr;
        berr_we_reg   <= bus_we;
        berr_ovf_reg  <= 1'b0;
      end else begin
        berr_ovf_reg  <= 1'b1;
      end
    end else if (berr_clr) begin
      berr_irq_reg <= 1'b0;
      berr_ovf_reg <= 1'b0;
    end
  end

  assign berr_irq  = berr_irq_reg;
  assign berr_addr = berr_addr_reg;
  assign berr_we   = berr_we_reg;
  assign berr_ovf  = berr_ovf_reg;

endmodule

// File: tb/tb_bus_ictl.sv
// Scoreboard bench for bus_ictl with four slaves and TIMEOUT=8.
// The stimulus process queues the expected ack responses, and a negedge monitor checks them.
module tb_bus_ictl;

  localparam int NSLV = 4;
  localparam logic [NSLV*30-1:0] BASES = {30'h0C000400, 30'h0C000000, 30'h08000000, 30'h00000000};
  localparam logic [NSLV*30-1:0] MASKS = {30'h3FFFFC00, 30'h3FFFFC00, 30'h3C000000, 30'h38000000};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 bus_stb;
  logic                 bus_we;
  logic [29:0]          bus_addr;
  logic [31:0]          bus_din;
  logic                 bus_ack;
  logic [NSLV-1:0]      slv_stb;
  logic [NSLV*32-1:0]   slv_dout;
  logic [NSLV-1:0]      slv_ack;
  logic                 berr_irq;
  logic [29:0]          berr_addr;
  logic                 berr_we;
  logic                 berr_ovf;
  logic                 berr_clr;

  always #5 clk = ~clk;

  bus_ictl #(
    .NSLV     (NSLV),
    .SLV_BASE (BASES),
    .SLV_MASK (MASKS),
    .TIMEOUT  (8),
    .TW       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din),
    .bus_ack   (bus_ack),
    .slv_stb   (slv_stb),
    .slv_dout  (slv_dout),
    .slv_ack   (slv_ack),
    .berr_irq  (berr_irq),
    .berr_addr (berr_addr),
    .berr_we   (berr_we),
    .berr_ovf  (berr_ovf),
    .berr_clr  (berr_clr)
  );

  typedef struct packed {
    logic [31:0] din;
    logic [3:0]  stb;
    logic        irq;
    logic [29:0] addr;
    logic        we;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference copy of the error registers
  logic        m_irq = 1'b0;
  logic [29:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic        m_ovf = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Monitor: every ack the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus_ack) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with empty queue, required no ack");
      end else begin
        mon_e = sb.pop_front();
        chk("ack din", bus_din, mon_e.din);
        chk("ack slv_stb", slv_stb, mon_e.stb);
        chk("ack berr_irq", berr_irq, mon_e.irq);
        chk("ack berr_addr", berr_addr, mon_e.addr);
        chk("ack berr_we", berr_we, mon_e.we);
        chk("ack berr_ovf", berr_ovf, mon_e.ovf);
        $display("[TB] ack addr=%07h din=%08h stb=%b irq=%b ovf=%b", bus_addr, bus_din, slv_stb, berr_irq, berr_ovf);
      end
    end
  end

  // One master cycle.
  // tgt=-1 means no slave answers, and ack_at=-1 means the slave never acks.
  // clr pulses berr_clr on the cycle the error would be captured.
  task automatic xfer(input string nm, input logic [29:0] a, input logic w, input int tgt,
                      input int ack_at, input logic [31:0] d, input logic clr, input logic is_err,
                      input int exp_lat, input logic [3:0] exp_stb);
    exp_t e;
    int   cyc;
    bit   done;
    if (is_err) begin
      if (!m_irq || clr) begin
        m_irq = 1'b1; m_addr = a; m_we = w; m_ovf = 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end
    e.din = is_err ? 32'h0 : d;
    e.stb = is_err ? 4'b0000 : exp_stb;
    e.irq = m_irq; e.addr = m_addr; e.we = m_we; e.ovf = m_ovf;
    sb.push_back(e);
    if (tgt >= 0) slv_dout[32*tgt +: 32] = d;
    bus_addr = a; bus_we = w; bus_stb = 1'b1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      slv_ack  = (tgt >= 0 && cyc == ack_at) ? (4'b0001 << tgt) : 4'b0000;
      berr_clr = clr && (cyc == exp_lat - 1);
      @(negedge clk);
      if (bus_ack) begin
        chk({nm, " latency"}, cyc, exp_lat);
        done = 1;
      end else begin
        chk({nm, " wait slv_stb"}, slv_stb, exp_stb);
      end
      @(posedge clk); #1;
      if (!done) cyc++;
    end
    if (!done) chk({nm, " ack bound"}, cyc, exp_lat);
    bus_stb = 1'b0; slv_ack = '0; berr_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    berr_clr = 1'b1;
    @(posedge clk); #1;
    berr_clr = 1'b0;
    m_irq = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    chk("clr berr_irq", berr_irq, m_irq);
    chk("clr berr_ovf", berr_ovf, m_ovf);
    $display("[TB] berr_clr irq=%b ovf=%b", berr_irq, berr_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_addr = '0;
    slv_ack = '0; berr_clr = 1'b0;
    slv_dout = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset slv_stb", slv_stb, 4'b0000);
    chk("reset bus_ack", bus_ack, 1'b0);
    chk("reset berr", {berr_irq, berr_addr, berr_we, berr_ovf}, 33'h0);
    $display("[TB] reset state checked");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal reads and writes, with error capture and overflow
    xfer("rd_s0", 30'h0000010, 1'b0, 0, 0, 32'h12345678, 1'b0, 1'b0, 0, 4'b0001);
    xfer("rd_unmapped", 30'h10000000, 1'b0, -1, -1, 32'h0, 1'b0, 1'b1, 1, 4'b0000);
    xfer("wr_unmapped_ovf", 30'h20000000, 1'b1, -1, -1, 32'h0, 1'b0, 1'b1, 1, 4'b0000);
    pulse_clr();
    xfer("wr_s2_timeout", 30'h0C000001, 1'b1, 2, -1, 32'hAAAA5555, 1'b0, 1'b1, 8, 4'b0100);
    pulse_clr();
    xfer("wr_s2_last_ack", 30'h0C000001, 1'b1, 2, 7, 32'hCAFEF00D, 1'b0, 1'b0, 7, 4'b0100);
    xfer("rd_s3", 30'h0C000404, 1'b0, 3, 1, 32'h33334444, 1'b0, 1'b0, 1, 4'b1000);
    // 0x4000000 only differs from slave 0 in a don't-care bit
    xfer("rd_s0_hi", 30'h04000000, 1'b0, 0, 2, 32'h0BADBEEF, 1'b0, 1'b0, 2, 4'b0001);

    // A clear that coincides with a new error gives a fresh capture
    xfer("err_a", 30'h10000100, 1'b0, -1, -1, 32'h0, 1'b0, 1'b1, 1, 4'b0000);
    xfer("err_b", 30'h10000200, 1'b1, -1, -1, 32'h0, 1'b0, 1'b1, 1, 4'b0000);
    xfer("err_c_clr", 30'h2000ABCD, 1'b1, -1, -1, 32'h0, 1'b1, 1'b1, 1, 4'b0000);
    pulse_clr();

    // Master abort in WAIT: no error, and the counter restarts from zero
    bus_addr = 30'h0C000010; bus_we = 1'b0; bus_stb = 1'b1; slv_ack = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort wait ack", bus_ack, 1'b0);
      @(posedge clk); #1;
    end
    bus_stb = 1'b0;
    @(negedge clk);
    chk("abort slv_stb", slv_stb, 4'b0000);
    @(posedge clk); #1;
    chk("abort berr_irq", berr_irq, m_irq);
    $display("[TB] master abort irq=%b", berr_irq);
    xfer("rd_s2_timeout", 30'h0C000010, 1'b0, 2, -1, 32'h0, 1'b0, 1'b1, 8, 4'b0100);

    // Reset during WAIT while an error is pending
    bus_addr = 30'h0C000020; bus_we = 1'b1; bus_stb = 1'b1; slv_ack = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst slv_stb", slv_stb, 4'b0000);
    chk("rst bus_ack", bus_ack, 1'b0);
    chk("rst berr", {berr_irq, berr_addr, berr_we, berr_ovf}, 33'h0);
    $display("[TB] async reset during WAIT");
    m_irq = 1'b0; m_addr = '0; m_we = 1'b0; m_ovf = 1'b0;
    bus_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer("rd_s1", 30'h08000010, 1'b0, 1, 2, 32'h5A5AA5A5, 1'b0, 1'b0, 2, 4'b0010);

    repeat (3) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
